register_rx: RTL and testbench
==============================

# register_rx

UART receive register for the serial link: recovers 8-N-1 frames from an asynchronous line using a 16x oversampling tick and presents each received byte with a valid/ack handshake. It is the receive-side counterpart of the transmit shift register, sits between the pad input and the byte consumer, and reports framing and overrun errors.

## Interface

Parameters:
- OVS, 16, ticks per bit; the sample point is tick OVS/2-1 of the start bit, then every OVS ticks after it.
- NBIT, 8, data bits per frame, LSB first.

Ports:
- clk_i  input  1  system clock; the only clock in the block.
- rst_i  input  1  asynchronous active-low reset.
- tick_i  input  1  single-cycle enable at OVS × baud rate; all bit timing advances only on cycles where it is high.
- rx_i  input  1  serial line, idle high, asynchronous to clk_i.
- ack_i  input  1  consumer has taken data_o.
- data_o  output  NBIT  last accepted byte.
- valid_o  output  1  data_o holds an unacknowledged byte.
- ferr_o  output  1  framing error: stop bit sampled 0.
- ovr_o  output  1  overrun: a frame completed while valid_o was high.
- busy_o  output  1  high in any state except IDLE.

## Operation

- rx_i passes through a two-flop synchronizer (rx_s); both flops reset to 1. Only rx_s is used.
- Tick counter cnt: 4 bits for OVS=16, width $clog2(OVS). Bit index bidx: 0..NBIT-1. Shift register sh: NBIT bits.
- FSM states:
  - IDLE: on a tick with rx_s==0, go to START with cnt=0.
  - START: each tick increments cnt. At cnt==OVS/2-1, sample the start bit. Sample 0 goes to DATA with cnt=0 and bidx=0. Sample 1 is a glitch and returns to IDLE.
  - DATA: at cnt==OVS-1, sample the bit. Shift right with the sample entering sh[NBIT-1], reset cnt to 0, increment bidx. After bidx==NBIT-1 is sampled, go to STOP.
  - STOP: at cnt==OVS-1, sample the stop bit.
    - Sample 1: commit sh per the handshake rules, clear ferr_o, go to IDLE.
    - Sample 0: set ferr_o, discard sh, go to WAIT.
  - WAIT (break/line stuck low): go to IDLE on the first tick with rx_s==1.
- Handshake:
  - Commit with valid_o==0: data_o<=sh, valid_o<=1.
  - Commit with valid_o==1 and ack_i==0: new byte dropped, data_o unchanged, ovr_o<=1.
  - Commit in the same cycle as ack_i==1: new byte loaded, valid_o stays 1, ovr_o unchanged.
  - ack_i while valid_o==1 without a commit: clears valid_o and ovr_o on the next edge.
  - ack_i while valid_o==0: ignored.
- ferr_o is sticky until the next good frame or reset; it is not cleared by ack_i.
- Reset (any time, including mid-frame):
  - state=IDLE, cnt=0, bidx=0, sh=0.
  - data_o=0, valid_o=0, ferr_o=0, ovr_o=0, busy_o=0.
  - Synchronizer flops =1.
  - A partially received frame is lost.

## Timing

- rx_s lags rx_i by 2 clk_i cycles.
- Start detection happens on the first tick after rx_s falls. This gives up to 1 tick of phase uncertainty, which is acceptable at OVS=16.
- Sample points fall at mid-bit: tick 7 of the start bit, then ticks 23, 39, and so on from the detected edge.
- valid_o, data_o and ovr_o update on the clk_i edge following the stop-bit sample tick, which is 1 cycle of latency.
- The stop-bit sample occurs (NBIT+1)×OVS + OVS/2-1 ticks after start detection.
- Back-to-back frames: a new start bit is accepted on the first tick after returning to IDLE. No minimum idle time is required.
- tick_i high on consecutive clk_i cycles is legal; each high cycle counts.

## Configuration

- RX_MAJORITY_EN defined: every sample point (start, data, stop) uses the majority of rx_s captured on ticks cnt-1, cnt and cnt+1 around the nominal point, using a 2-bit history plus the following tick. State advances on the later tick, adding one tick of latency to each sample.
- RX_MAJORITY_EN undefined: single sample of rx_s at the nominal tick.

## Test plan

- Byte frame: tick_i every 4 clk, send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1). Required: data_o=0xA5, valid_o=1, ferr_o=0, ovr_o=0. Then ack_i pulse, required: valid_o=0 next cycle.
- Start glitch: rx_i low for 4 ticks then high. Required: no valid_o, busy_o returns 0 after tick 7, and a following 0x3C frame is received correctly.
- Framing error: send 0x55 with stop bit 0, hold low 20 ticks, then high. Required: ferr_o=1, valid_o=0, state returns to IDLE only after line high. A next good frame 0x12 gives ferr_o=0, data_o=0x12.
- Overrun: send 0x11 then 0x22 with no ack. Required: data_o=0x11, valid_o=1, ovr_o=1. ack_i clears both. A commit coinciding with ack_i loads the new byte with ovr_o=0.
- Reset mid-frame: assert rst_i low at bit 4 of 0xF0. Required: all outputs 0 immediately. After release, 0x81 is received correctly.
- With RX_MAJORITY_EN: a 1-tick low glitch exactly at the data-bit-2 sample point of 0xFF. Required: data_o=0xFF. Without the macro, data_o=0xFB.

Source files
------------

// File: rtl/register_rx_if.sv
// register_rx_if: byte-receive bus of the UART receive register.
//   tick_i  : one-cycle enable at OVS x baud
//   rx_i    : serial line, idle high, asynchronous to the clock
//   ack_i   : consumer has taken data_o
//   data_o  : last accepted byte
//   valid_o : data_o holds an unacknowledged byte
//   ferr_o  : framing error (sticky until the next good frame)
//   ovr_o   : a frame completed while valid_o was high
//   busy_o  : receiver is not idle
// master = line/consumer side, slave = receiver.
interface register_rx_if #(
    parameter int NBIT = 8
);
    logic            tick_i;
    logic            rx_i;
    logic            ack_i;
    logic [NBIT-1:0] data_o;
    logic            valid_o;
    logic            ferr_o;
    logic            ovr_o;
    logic            busy_o;

    modport master (
        output tick_i, rx_i, ack_i,
        input  data_o, valid_o, ferr_o, ovr_o, busy_o
    );

    modport slave (
        input  tick_i, rx_i, ack_i,
        output data_o, valid_o, ferr_o, ovr_o, busy_o
    );
endinterface

// File: rtl/register_rx.sv
// register_rx: UART 8-N-1 receive register with 16x oversampling.
// Recovers frames from bus.rx_i, presents each byte on data_o with a
// valid/ack handshake, and flags framing errors and overruns.
//   clk_i : system clock
//   rst_i : asynchronous active-low reset
//   bus   : register_rx_if.slave (tick_i, rx_i, ack_i in;
//           data_o, valid_o, ferr_o, ovr_o, busy_o out)
// Optional feature macro: RX_MAJORITY_EN -- each sample point takes the
// majority of three consecutive tick samples centred on the nominal tick;
// decisions land one tick later.
module register_rx #(
    parameter int OVS  = 16,
    parameter int NBIT = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    register_rx_if.slave bus
);

    localparam int CW = $clog2(OVS);
    localparam int BW = (NBIT > 1) ? $clog2(NBIT) : 1;
`ifdef RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // The start decision is taken on the tick where cnt would reach OVS/2-1,
    // i.e. tick OVS/2-1 after the detection tick. With majority voting the
    // whole sampling grid slides one tick later, so only this point moves;
    // data/stop points stay OVS ticks apart.
    localparam logic [CW-1:0] START_PT = CW'(OVS/2 - 2 + MAJ);
    localparam logic [CW-1:0] BIT_PT   = CW'(OVS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NBIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bidx;
    logic [NBIT-1:0] sh;
    logic            rx_m, rx_s;
    logic            smp;
    logic [NBIT-1:0] data_q;
    logic            valid_q, ferr_q, ovr_q, busy_q;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx_i;
            rx_s <= rx_m;
        end
    end

`ifdef RX_MAJORITY_EN
    // hist[1] = rx_s two ticks ago, hist[0] = one tick ago.
    logic [1:0] hist;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)          hist <= 2'b11;
        else if (bus.tick_i) hist <= {hist[0], rx_s};
    end

    assign smp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign smp = rx_s;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bidx    <= '0;
            sh      <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // Consumer ack; a commit in the same cycle overrides below.
            if (bus.ack_i && valid_q) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
            if (bus.tick_i) begin
                case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state  <= S_START;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (cnt == START_PT) begin
                            cnt <= '0;
                            if (!smp) begin
                                state <= S_DATA;
                                bidx  <= '0;
                            end else begin
                                // line came back high: glitch, not a start bit
                                state  <= S_IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (cnt == BIT_PT) begin
                            cnt <= '0;
                            sh  <= {smp, sh[NBIT-1:1]};
                            if (bidx == LAST_BIT) begin
                                bidx  <= '0;
                                state <= S_STOP;
                            end else begin
                                bidx <= bidx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (cnt == BIT_PT) begin
                            cnt <= '0;
                            if (smp) begin
                                state  <= S_IDLE;
                                busy_q <= 1'b0;
                                ferr_q <= 1'b0;
                                if (!valid_q || bus.ack_i) begin
                                    // free slot, or the old byte leaves this cycle
                                    data_q  <= sh;
                                    valid_q <= 1'b1;
                                    ovr_q   <= ovr_q;
                                end else begin
                                    ovr_q <= 1'b1;
                                end
                            end else begin
                                ferr_q <= 1'b1;
                                state  <= S_WAIT;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        // break / stuck-low line: hold off until it is released
                        if (rx_s) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.ferr_o  = ferr_q;
    assign bus.ovr_o   = ovr_q;
    assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_register_rx.sv
// tb_register_rx: directed + randomized bench for register_rx.
// The line is described per tick slot; a frame-level model resolves each
// frame from sample offsets counted from the detection tick and applies
// the handshake rules to produce the expected outputs.
module tb_register_rx;
    localparam int OVS  = 16;
    localparam int NBIT = 8;
`ifdef RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int STOP_OFS = OVS/2 - 1 + OVS*(NBIT+1);

    logic clk = 1'b0;
    logic rst;

    register_rx_if #(.NBIT(NBIT)) bus();

    register_rx #(.OVS(OVS), .NBIT(NBIT)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit         line[$];   // rx level seen on each tick since reset
    bit         seg[$];    // slots to play next
    int         nxt_idle;
    int         m_wait_from;
    logic [7:0] m_data;
    bit         m_valid, m_ovr, m_ferr, m_busy;

    function automatic bit lv(input int t);
        if (t < 0 || t >= line.size()) return 1'b1;
        return line[t];
    endfunction

    function automatic bit smp_at(input int n);
        if (MAJ != 0) return (int'(lv(n-1)) + int'(lv(n)) + int'(lv(n+1))) >= 2;
        return lv(n);
    endfunction

    function automatic void m_ack();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endfunction

    function automatic void m_commit(input logic [7:0] b, input bit ack);
        if (!m_valid) begin
            m_data  = b;
            m_valid = 1'b1;
        end else if (ack) begin
            m_data = b;
        end else begin
            m_ovr = 1'b1;
        end
        m_ferr = 1'b0;
    endfunction

    function automatic void m_reset();
        line.delete();
        nxt_idle    = 0;
        m_wait_from = -1;
        m_data      = '0;
        m_valid     = 0;
        m_ovr       = 0;
        m_ferr      = 0;
        m_busy      = 0;
    endfunction

    // Resolve every frame that completed within the recorded line.
    function automatic void m_run(input int ack_t);
        int         len, d, r, w;
        bit         pend, co;
        logic [7:0] b;
        len  = line.size();
        pend = (ack_t >= 0);
        while (1) begin
            if (m_wait_from >= 0) begin
                w = -1;
                for (int t = m_wait_from + 1; t < len; t++)
                    if (line[t]) begin w = t; break; end
                if (w < 0) begin m_busy = 1; break; end
                nxt_idle    = w + 1;
                m_wait_from = -1;
                continue;
            end
            d = -1;
            for (int t = nxt_idle; t < len; t++)
                if (!line[t]) begin d = t; break; end
            if (d < 0) begin nxt_idle = len; m_busy = 0; break; end
            m_busy = 1;
            r = d + OVS/2 - 1 + MAJ;
            if (r >= len) break;
            if (smp_at(r - MAJ)) begin nxt_idle = r + 1; continue; end
            b = '0;
            for (int k = 0; k < NBIT; k++) b[k] = smp_at(d + OVS/2 - 1 + OVS*(k+1));
            r = d + STOP_OFS + MAJ;
            if (r >= len) break;
            if (pend && ack_t < r) begin m_ack(); pend = 0; end
            co = pend && (ack_t == r);
            if (co) pend = 0;
            if (smp_at(r - MAJ)) begin
                m_commit(b, co);
                nxt_idle = r + 1;
            end else begin
                m_ferr = 1'b1;
                if (co) m_ack();
                m_wait_from = r;
            end
        end
        if (pend) m_ack();
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) seg.push_back(1'b1);
    endtask

    task automatic add_low(input int n);
        for (int i = 0; i < n; i++) seg.push_back(1'b0);
    endtask

    task automatic add_frame(input logic [7:0] b, input bit stp, input int stop_len);
        add_low(OVS);
        for (int k = 0; k < NBIT; k++)
            for (int i = 0; i < OVS; i++) seg.push_back(b[k]);
        for (int i = 0; i < stop_len; i++) seg.push_back(stp);
    endtask

    // One tick every 4 clocks; rx changes 4 clocks before the tick so the
    // synchronized level is settled when the tick is taken.
    task automatic play(input int ack_slot);
        int base;
        base = line.size();
        foreach (seg[i]) line.push_back(seg[i]);
        foreach (seg[i]) begin
            bus.rx_i = seg[i];
            repeat (3) @(negedge clk);
            bus.tick_i = 1'b1;
            bus.ack_i  = (i == ack_slot);
            @(negedge clk);
            bus.tick_i = 1'b0;
            bus.ack_i  = 1'b0;
        end
        m_run(ack_slot >= 0 ? base + ack_slot : -1);
        seg.delete();
    endtask

    task automatic ack_pulse();
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        m_ack();
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "/data"},  32'(bus.data_o),  32'(m_data));
        chk({tag, "/valid"}, 32'(bus.valid_o), 32'(m_valid));
        chk({tag, "/ferr"},  32'(bus.ferr_o),  32'(m_ferr));
        chk({tag, "/ovr"},   32'(bus.ovr_o),   32'(m_ovr));
        chk({tag, "/busy"},  32'(bus.busy_o),  32'(m_busy));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        bit         stp;
        int         gap, ack_slot, sel, gidx;

        rst = 1'b0;
        bus.tick_i = 1'b0;
        bus.rx_i   = 1'b1;
        bus.ack_i  = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk_all("reset");
        rst = 1'b1;
        @(negedge clk);

        // 0xA5, segment ends on the stop-sample tick: outputs visible one edge later
        add_idle(2);
        add_frame(8'hA5, 1'b1, OVS/2 + MAJ);
        play(-1);
        chk("a5_data", 32'(bus.data_o), 32'hA5);
        chk("a5_valid", 32'(bus.valid_o), 32'd1);
        chk_all("a5");
        add_idle(OVS/2);
        play(-1);
        ack_pulse();
        chk("a5_ack_valid", 32'(bus.valid_o), 32'd0);

        // start glitch: 4 low ticks, then high
        add_idle(3);
        add_low(4);
        add_idle(2);
        play(-1);
        chk("glitch_busy_mid", 32'(bus.busy_o), 32'd1);
        add_idle(4);
        play(-1);
        chk("glitch_busy_end", 32'(bus.busy_o), 32'd0);
        chk_all("glitch");
        add_frame(8'h3C, 1'b1, OVS);
        add_idle(2);
        play(-1);
        chk("after_glitch_data", 32'(bus.data_o), 32'h3C);
        chk_all("after_glitch");
        ack_pulse();

        // framing error, line held low, then released
        add_idle(2);
        add_frame(8'h55, 1'b0, OVS);
        add_low(20);
        play(-1);
        chk("ferr_set", 32'(bus.ferr_o), 32'd1);
        chk("ferr_busy_low", 32'(bus.busy_o), 32'd1);
        chk_all("ferr_hold");
        add_idle(4);
        play(-1);
        chk("ferr_busy_rel", 32'(bus.busy_o), 32'd0);
        chk_all("ferr_rel");
        add_frame(8'h12, 1'b1, OVS);
        add_idle(2);
        play(-1);
        chk("ferr_clr", 32'(bus.ferr_o), 32'd0);
        chk("ferr_next_data", 32'(bus.data_o), 32'h12);
        ack_pulse();

        // overrun, ack clears, then commit coinciding with ack
        add_frame(8'h11, 1'b1, OVS);
        add_frame(8'h22, 1'b1, OVS);
        add_idle(2);
        play(-1);
        chk("ovr_data", 32'(bus.data_o), 32'h11);
        chk("ovr_flag", 32'(bus.ovr_o), 32'd1);
        chk_all("ovr");
        ack_pulse();
        chk_all("ovr_ack");
        add_frame(8'h33, 1'b1, OVS);
        add_idle(2);
        play(-1);
        add_idle(2);
        add_frame(8'h44, 1'b1, OVS);
        add_idle(4);
        play(2 + STOP_OFS + MAJ);
        chk("coack_data", 32'(bus.data_o), 32'h44);
        chk("coack_ovr", 32'(bus.ovr_o), 32'd0);
        chk_all("coack");
        ack_pulse();

        // randomized frames, errors, acks
        for (int it = 0; it < 16; it++) begin
            b        = 8'($urandom);
            stp      = ($urandom_range(0, 4) != 0);
            gap      = $urandom_range(0, 3);
            sel      = $urandom_range(0, 3);
            ack_slot = -1;
            add_idle(gap);
            if (sel == 0)      ack_slot = gap + STOP_OFS + MAJ;
            else if (sel == 1) ack_slot = $urandom_range(0, gap + OVS*(NBIT+2) - 1);
            add_frame(b, stp, OVS);
            if (!stp) begin
                add_low($urandom_range(0, 10));
                add_idle(2);
            end
            play(ack_slot);
            chk_all($sformatf("rand%0d", it));
            if ($urandom_range(0, 2) == 0) ack_pulse();
        end
        ack_pulse();

        // one-tick low glitch on the data-bit-2 sample point of 0xFF
        add_idle(2);
        gidx = seg.size() + OVS/2 - 1 + OVS*3;
        add_frame(8'hFF, 1'b1, OVS);
        seg[gidx] = 1'b0;
        add_idle(2);
        play(-1);
        chk("maj_data", 32'(bus.data_o), (MAJ != 0) ? 32'hFF : 32'hFB);
        chk_all("maj");

        // reset in the middle of 0xF0 (during bit 4), valid still set
        add_idle(2);
        add_low(OVS);
        add_low(OVS*4);
        add_idle(OVS/2);
        play(-1);
        chk("pre_rst_busy", 32'(bus.busy_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_data",  32'(bus.data_o),  32'd0);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_ferr",  32'(bus.ferr_o),  32'd0);
        chk("rst_ovr",   32'(bus.ovr_o),   32'd0);
        chk("rst_busy",  32'(bus.busy_o),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        add_idle(3);
        add_frame(8'h81, 1'b1, OVS);
        add_idle(4);
        play(-1);
        chk("post_rst_data", 32'(bus.data_o), 32'h81);
        chk_all("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
